axi4lite_apb_bridge: RTL and testbench
======================================

// Module: axi4lite_apb_bridge
// PURPOSE
//  AXI4-Lite slave to APB4 master bridge with NUM_SLV decoded APB targets.
//  Sits between the system AXI4-Lite interconnect and the peripheral APB segment.
//  Serialises reads and writes, one transaction in flight.
//  Maps PSLVERR and undecoded addresses onto AXI BRESP/RRESP.
// PARAMETERS
//  ADDR_W      32   AXI/APB address width
//  DATA_W      32   data width (32 or 64); STRB_W = DATA_W/8
//  NUM_SLV     4    number of APB targets, 1..16; SEL_W = max(1, $clog2(NUM_SLV))
//  SLV_AW      12   per-target window: index = addr[SLV_AW +: SEL_W]
//  TIMEOUT_CYC 256  ACCESS-phase wait limit (APB_TIMEOUT_EN only)
// PORTS
//  aclk                     in   1              clock
//  aresetn                  in   1              async reset, active low
//  awaddr/awprot            in   ADDR_W/3       write address channel
//  awvalid / awready        in/out 1            write address handshake
//  wdata/wstrb              in   DATA_W/STRB_W  write data channel
//  wvalid / wready          in/out 1            write data handshake
//  bresp                    out  2              write response
//  bvalid / bready          out/in 1            write response handshake
//  araddr/arprot            in   ADDR_W/3       read address channel
//  arvalid / arready        in/out 1            read address handshake
//  rdata/rresp              out  DATA_W/2       read data, read response
//  rvalid / rready          out/in 1            read response handshake
//  paddr                    out  ADDR_W         APB address (full AXI address)
//  psel                     out  NUM_SLV        one-hot target select
//  penable/pwrite           out  1/1            APB phase, direction
//  pwdata/pstrb/pprot       out  DATA_W/STRB_W/3 APB write data, strobes, protection
//  prdata                   in   NUM_SLV*DATA_W packed target read data, target i at [i*DATA_W +: DATA_W]
//  pready/pslverr           in   NUM_SLV/NUM_SLV per-target ready and error
// BEHAVIOUR
//  Reset: every output 0; state IDLE; arbitration favours write first.
//  FSM states:
//   - IDLE: grant one request, then go to SETUP, or to RESP if the address is undecoded.
//   - SETUP: psel[idx]=1, penable=0. Always exactly 1 cycle, then ACCESS.
//   - ACCESS: psel[idx]=1, penable=1. Stay until pready[idx]; then capture prdata and pslverr.
//   - RESP: bvalid or rvalid held until bready or rready. On the handshake -> IDLE.
//  Write request: awvalid AND wvalid both high. AW or W alone is never accepted.
//  Grant: awready and wready pulse together for 1 cycle (combinational in IDLE).
//   arready pulses alone for reads.
//  Arbitration when both requests are pending: round-robin. Last-granted direction loses.
//  Capture at grant: addr, prot, wdata, wstrb.
//   - pwrite = 1 for writes.
//   - pstrb = wstrb for writes; pstrb = 0 for reads.
//   - pwdata = 0 for reads.
//  APB outputs are registered. paddr/pwrite/pwdata/pstrb/pprot stay stable from SETUP through the ACCESS end.
//  Outside SETUP/ACCESS: psel=0, penable=0.
//  Decode: idx >= NUM_SLV -> no APB cycle. Response DECERR (2'b11); rdata = 0.
//  Response codes:
//   - pslverr[idx]=1 at completion -> SLVERR (2'b10).
//   - Otherwise OKAY (2'b00).
//   - rdata = prdata slice of idx. rdata is only meaningful while rvalid=1.
//  Latency, no wait states:
//   - grant at cycle 0, SETUP at 1, ACCESS at 2, bvalid/rvalid at 3.
//   - Each low-pready cycle adds 1 cycle.
//   - DECERR: bvalid/rvalid at cycle 1.
//  bvalid/rvalid, bresp/rresp and rdata hold while the master stalls. No new grant is made until the response handshake completes.
//  pready from non-selected targets is ignored.
//  Reset asserted mid-transfer: psel, penable, bvalid and rvalid drop asynchronously. The transaction is discarded.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//   - A counter runs in ACCESS.
//   - After TIMEOUT_CYC consecutive cycles with pready[idx]=0, psel and penable deassert next cycle.
//   - The response is SLVERR with rdata = 0.
//   - The counter clears on entry to SETUP.
//  APB_TIMEOUT_EN undefined: ACCESS waits indefinitely. TIMEOUT_CYC is unused. No counter logic is generated.
// TESTING
//  Write 0x0000_1004 data 0xA5A5_5A5A, wstrb 0xF, pready=1 -> psel=4'b0010 for 2 cycles. pwdata=0xA5A5_5A5A. bresp=OKAY at cycle 3.
//  Read 0x0000_3008, pready low 3 cycles, prdata[3]=0x1234_5678 -> rvalid at cycle 6, rdata=0x1234_5678, rresp=OKAY.
//  Read 0x0000_2000 with pslverr[2]=1 -> rresp=2'b10. Read 0x0000_5000 (NUM_SLV=4) -> psel stays 0, rresp=2'b11 at cycle 1.
//  AW/W and AR valid together, twice back to back -> order write, read, write, read. awready and wready always coincident.
//  bready held low 5 cycles -> bvalid/bresp stable; arvalid meanwhile is not granted until the B handshake.
//  aresetn low during ACCESS -> all outputs 0 immediately. With APB_TIMEOUT_EN and pready stuck low -> SLVERR after 256 ACCESS cycles.

Source files
------------

// File: rtl/axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge, one transaction in flight, NUM_SLV decoded targets.
// Optional: define APB_TIMEOUT_EN to terminate ACCESS after TIMEOUT_CYC wait cycles with SLVERR.
module axi4lite_apb_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int SLV_AW      = 12,
  parameter int TIMEOUT_CYC = 256,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDR_W-1:0]         awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [STRB_W-1:0]         wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_W-1:0]         araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [ADDR_W-1:0]         paddr,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic [STRB_W-1:0]         pstrb,
  output logic [2:0]                pprot,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                last_wr_q, last_wr_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                bvalid_q, bvalid_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  logic                wr_req, rd_req, grant_wr, grant_rd, req_decoded;
  logic [ADDR_W-1:0]   req_addr;
  logic [SEL_W-1:0]    req_idx;

  // Writes win a tie unless the previous grant was also a write (round-robin).
  assign wr_req   = awvalid & wvalid;
  assign rd_req   = arvalid;
  assign grant_wr = aresetn && (state_q == S_IDLE) && wr_req && (!rd_req || !last_wr_q);
  assign grant_rd = aresetn && (state_q == S_IDLE) && rd_req && !grant_wr;

  // The whole region number above the window must be in range, not just the index bits.
  assign req_addr    = grant_wr ? awaddr : araddr;
  assign req_idx     = req_addr[SLV_AW +: SEL_W];
  assign req_decoded = (req_addr >> SLV_AW) < ADDR_W'(NUM_SLV);

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    idx_d     = idx_q;
    paddr_d   = paddr_q;
    pprot_d   = pprot_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_wr || grant_rd) begin
          last_wr_d = grant_wr;
          idx_d     = req_idx;
          paddr_d   = req_addr;
          pprot_d   = grant_wr ? awprot : arprot;
          pwrite_d  = grant_wr;
          pwdata_d  = grant_wr ? wdata : '0;
          pstrb_d   = grant_wr ? wstrb : '0;
          if (req_decoded) begin
            psel_d          = '0;
            psel_d[req_idx] = 1'b1;
            state_d         = S_SETUP;
`ifdef APB_TIMEOUT_EN
            cnt_d           = '0;
`endif
          end else begin
            resp_d   = 2'b11;
            rdata_d  = '0;
            bvalid_d = grant_wr;
            rvalid_d = grant_rd;
            state_d  = S_RESP;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready[idx_q]) begin
          resp_d    = pslverr[idx_q] ? 2'b10 : 2'b00;
          rdata_d   = prdata[idx_q*DATA_W +: DATA_W];
          psel_d    = '0;
          penable_d = 1'b0;
          bvalid_d  = pwrite_q;
          rvalid_d  = !pwrite_q;
          state_d   = S_RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          resp_d    = 2'b10;
          rdata_d   = '0;
          psel_d    = '0;
          penable_d = 1'b0;
          bvalid_d  = pwrite_q;
          rvalid_d  = !pwrite_q;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if ((bvalid_q && bready) || (rvalid_q && rready)) begin
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      last_wr_q <= 1'b0;
      idx_q     <= '0;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      resp_q    <= '0;
      rdata_q   <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      idx_q     <= idx_d;
      paddr_q   <= paddr_d;
      pprot_q   <= pprot_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign awready = grant_wr;
  assign wready  = grant_wr;
  assign arready = grant_rd;
  assign bvalid  = bvalid_q;
  assign bresp   = resp_q;
  assign rvalid  = rvalid_q;
  assign rresp   = resp_q;
  assign rdata   = rdata_q;
  assign paddr   = paddr_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign pstrb   = pstrb_q;
  assign pprot   = pprot_q;

endmodule

// File: tb/tb_axi4lite_apb_bridge.sv
// Directed self-checking bench for axi4lite_apb_bridge (NUM_SLV=4, 32-bit).
module tb_axi4lite_apb_bridge;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NUM_SLV = 4;
  localparam int STRB_W = DATA_W / 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0, paddr;
  logic [2:0] awprot = '0, arprot = '0, pprot;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic awready, wready, arready, bvalid, rvalid, penable, pwrite;
  logic [DATA_W-1:0] wdata = '0, rdata, pwdata;
  logic [STRB_W-1:0] wstrb = '0, pstrb;
  logic [1:0] bresp, rresp;
  logic [NUM_SLV-1:0] psel;
  logic [NUM_SLV*DATA_W-1:0] prdata = {32'h1234_5678, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
  logic [NUM_SLV-1:0] pready = '1, pslverr = '0;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi4lite_apb_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .SLV_AW(12), .TIMEOUT_CYC(256)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic test_reset();
    aresetn = 1'b0;
    #3;
    checks++; if ({psel, penable, pwrite, bvalid, rvalid, awready, wready, arready} !== 11'b0)
      begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {psel, penable, pwrite, bvalid, rvalid, awready, wready, arready}); end
    checks++; if ({paddr, pwdata, pstrb, pprot, bresp, rresp, rdata} !== '0)
      begin failures++; $display("FAIL reset_data got=%h exp=0", {paddr, pwdata, pstrb, pprot, bresp, rresp, rdata}); end
    @(negedge aclk); aresetn = 1'b1;
  endtask

  task automatic test_write();
    @(posedge aclk); #1;
    awaddr = 32'h0000_1004; awprot = 3'b010; wdata = 32'hA5A5_5A5A; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; pready = '1; bready = 1'b1;
    @(negedge aclk);
    checks++; if ({awready, wready, arready} !== 3'b110)
      begin failures++; $display("FAIL write_grant got=%b exp=110", {awready, wready, arready}); end
    @(posedge aclk); #1; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    checks++; if ({psel, penable} !== 5'b0010_0)
      begin failures++; $display("FAIL write_setup got=%b exp=00100", {psel, penable}); end
    checks++; if ({paddr, pwrite, pwdata, pstrb, pprot} !== {32'h0000_1004, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'b010})
      begin failures++; $display("FAIL write_apb_fields got=%h %b %h %h %b", paddr, pwrite, pwdata, pstrb, pprot); end
    @(negedge aclk);
    checks++; if ({psel, penable, bvalid} !== 6'b0010_1_0)
      begin failures++; $display("FAIL write_access got=%b exp=001010", {psel, penable, bvalid}); end
    @(negedge aclk);
    checks++; if ({bvalid, bresp, psel, penable} !== 8'b1_00_0000_0)
      begin failures++; $display("FAIL write_bresp got=%b exp=10000000", {bvalid, bresp, psel, penable}); end
    @(negedge aclk);
    checks++; if (bvalid !== 1'b0)
      begin failures++; $display("FAIL write_bdone got=%b exp=0", bvalid); end
  endtask

  task automatic test_read_wait();
    @(posedge aclk); #1;
    araddr = 32'h0000_3008; arprot = 3'b001; arvalid = 1'b1; rready = 1'b1; pready = 4'b0111;
    @(negedge aclk);
    checks++; if ({awready, arready} !== 2'b01)
      begin failures++; $display("FAIL read_grant got=%b exp=01", {awready, arready}); end
    @(posedge aclk); #1; arvalid = 1'b0;
    @(negedge aclk);
    checks++; if ({psel, penable, pwrite, pstrb, pwdata, paddr, pprot} !== {4'b1000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0000_3008, 3'b001})
      begin failures++; $display("FAIL read_setup got=%b %b %b %h %h %h", psel, penable, pwrite, pstrb, pwdata, paddr); end
    for (int c = 2; c <= 4; c++) begin
      @(negedge aclk);
      checks++; if ({rvalid, psel, penable} !== 6'b0_1000_1)
        begin failures++; $display("FAIL read_wait_c%0d got=%b exp=010001", c, {rvalid, psel, penable}); end
    end
    @(posedge aclk); #1; pready = '1;
    @(negedge aclk);
    checks++; if ({rvalid, penable} !== 2'b01)
      begin failures++; $display("FAIL read_c5 got=%b exp=01", {rvalid, penable}); end
    @(negedge aclk);
    checks++; if ({rvalid, rresp, rdata, psel} !== {1'b1, 2'b00, 32'h1234_5678, 4'b0000})
      begin failures++; $display("FAIL read_c6 got=%b %b %h %b exp=1 00 12345678 0000", rvalid, rresp, rdata, psel); end
    @(negedge aclk);
    checks++; if (rvalid !== 1'b0)
      begin failures++; $display("FAIL read_rdone got=%b exp=0", rvalid); end
  endtask

  task automatic test_read_slverr();
    @(posedge aclk); #1;
    araddr = 32'h0000_2000; arvalid = 1'b1; pslverr = 4'b0100; pready = '1;
    @(posedge aclk); #1; arvalid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    checks++; if ({rvalid, psel} !== 5'b0_0100)
      begin failures++; $display("FAIL slverr_c2 got=%b exp=00100", {rvalid, psel}); end
    @(negedge aclk);
    checks++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b10, 32'hDEAD_0002})
      begin failures++; $display("FAIL slverr_resp got=%b %b %h exp=1 10 dead0002", rvalid, rresp, rdata); end
    @(posedge aclk); #1; pslverr = '0;
  endtask

  task automatic test_decerr();
    @(posedge aclk); #1;
    araddr = 32'h0000_5000; arvalid = 1'b1;
    @(negedge aclk);
    checks++; if (arready !== 1'b1)
      begin failures++; $display("FAIL decerr_grant got=%b exp=1", arready); end
    @(posedge aclk); #1; arvalid = 1'b0;
    @(negedge aclk);
    checks++; if ({rvalid, rresp, rdata, psel, penable} !== {1'b1, 2'b11, 32'h0, 4'b0, 1'b0})
      begin failures++; $display("FAIL decerr_c1 got=%b %b %h %b %b", rvalid, rresp, rdata, psel, penable); end
    @(negedge aclk);
    checks++; if ({rvalid, psel} !== 5'b0)
      begin failures++; $display("FAIL decerr_done got=%b exp=0", {rvalid, psel}); end
  endtask

  task automatic test_back_to_back();
    byte order[4];
    byte exp_c;
    int n = 0, wg = 0, rg = 0, bad = 0;
    foreach (order[i]) order[i] = 8'h00;
    @(posedge aclk); #1;
    awaddr = 32'h0000_0010; wdata = 32'h0000_0001; wstrb = 4'h3; araddr = 32'h0000_1010;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; pready = '1; bready = 1'b1; rready = 1'b1;
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(negedge aclk);
      if (awready !== wready) bad++;
      if (awready === 1'b1 && arready === 1'b1) bad++;
      if (awready === 1'b1) begin order[n] = "W"; n++; wg++; end
      else if (arready === 1'b1) begin order[n] = "R"; n++; rg++; end
      @(posedge aclk); #1;
      awvalid = (wg < 2); wvalid = (wg < 2); arvalid = (rg < 2);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++; if (n !== 4)
      begin failures++; $display("FAIL b2b_grants got=%0d exp=4", n); end
    checks++; if (bad !== 0)
      begin failures++; $display("FAIL b2b_ready_coincident got=%0d exp=0", bad); end
    for (int i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 0) ? "W" : "R";
      checks++; if (order[i] !== exp_c)
        begin failures++; $display("FAIL b2b_order_%0d got=%c exp=%c", i, order[i], exp_c); end
    end
    repeat (6) @(negedge aclk);
  endtask

  task automatic test_stall();
    int seen = 0;
    @(posedge aclk); #1;
    awaddr = 32'h0000_0000; wdata = 32'h0000_0011; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b0; rready = 1'b1; pready = '1;
    @(negedge aclk);
    checks++; if ({awready, wready} !== 2'b11)
      begin failures++; $display("FAIL stall_grant got=%b exp=11", {awready, wready}); end
    @(posedge aclk); #1; awvalid = 1'b0; wvalid = 1'b0; araddr = 32'h0000_1000; arvalid = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    for (int c = 3; c <= 7; c++) begin
      @(negedge aclk);
      checks++; if ({bvalid, bresp, arready} !== 4'b1_00_0)
        begin failures++; $display("FAIL stall_c%0d got=%b exp=1000", c, {bvalid, bresp, arready}); end
    end
    @(posedge aclk); #1; bready = 1'b1;
    @(negedge aclk);
    checks++; if ({bvalid, arready} !== 2'b10)
      begin failures++; $display("FAIL stall_c8 got=%b exp=10", {bvalid, arready}); end
    @(negedge aclk);
    checks++; if ({bvalid, arready} !== 2'b01)
      begin failures++; $display("FAIL stall_c9 got=%b exp=01", {bvalid, arready}); end
    @(posedge aclk); #1; arvalid = 1'b0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge aclk);
      if (rvalid === 1'b1) seen = 1;
    end
    checks++; if (seen !== 1 || rdata !== 32'hDEAD_0001)
      begin failures++; $display("FAIL stall_read got=%0d %h exp=1 dead0001", seen, rdata); end
    @(negedge aclk);
  endtask

  task automatic test_reset_mid();
    @(posedge aclk); #1;
    araddr = 32'h0000_1000; arvalid = 1'b1; pready = '0; rready = 1'b1;
    @(posedge aclk); #1; arvalid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    checks++; if ({psel, penable} !== 5'b0010_1)
      begin failures++; $display("FAIL rstmid_access got=%b exp=00101", {psel, penable}); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if ({psel, penable, rvalid, bvalid, arready, awready} !== 9'b0)
      begin failures++; $display("FAIL rstmid_async got=%b exp=0", {psel, penable, rvalid, bvalid, arready, awready}); end
    @(negedge aclk); aresetn = 1'b1; pready = '1;
    repeat (3) @(negedge aclk);
    checks++; if ({psel, penable, rvalid, bvalid} !== 7'b0)
      begin failures++; $display("FAIL rstmid_discard got=%b exp=0", {psel, penable, rvalid, bvalid}); end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int at = -1;
    @(posedge aclk); #1;
    araddr = 32'h0000_2004; arvalid = 1'b1; pready = '0; rready = 1'b1;
    @(posedge aclk); #1; arvalid = 1'b0;
    for (int c = 1; c <= 400 && at < 0; c++) begin
      @(negedge aclk);
      if (rvalid === 1'b1) at = c;
    end
    checks++; if (at !== 258)
      begin failures++; $display("FAIL timeout_cycle got=%0d exp=258", at); end
    checks++; if ({rresp, rdata, psel, penable} !== {2'b10, 32'h0, 4'b0, 1'b0})
      begin failures++; $display("FAIL timeout_resp got=%b %h %b %b", rresp, rdata, psel, penable); end
    @(posedge aclk); #1; pready = '1;
    @(negedge aclk);
  endtask
`else
  task automatic test_timeout();
    int at = -1;
    int early = 0;
    @(posedge aclk); #1;
    araddr = 32'h0000_2004; arvalid = 1'b1; pready = '0; rready = 1'b1;
    @(posedge aclk); #1; arvalid = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge aclk);
      if (rvalid === 1'b1) early++;
    end
    checks++; if (early !== 0 || {psel, penable} !== 5'b0100_1)
      begin failures++; $display("FAIL no_timeout_wait got=%0d %b exp=0 01001", early, {psel, penable}); end
    @(posedge aclk); #1; pready = 4'b0100;
    for (int c = 0; c < 5 && at < 0; c++) begin
      @(negedge aclk);
      if (rvalid === 1'b1) at = c;
    end
    checks++; if (at !== 1 || rresp !== 2'b00 || rdata !== 32'hDEAD_0002)
      begin failures++; $display("FAIL no_timeout_done got=%0d %b %h exp=1 00 dead0002", at, rresp, rdata); end
    @(posedge aclk); #1; pready = '1;
    @(negedge aclk);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_read_slverr();
    test_decerr();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
